// File: rtl/bubble_sort_ctrl_pkg.sv
// Shared definitions for the bubble-sort sequencer: state encoding and default entry count.
package bubble_sort_ctrl_pkg;

    localparam int DEFAULT_N = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_CMP  = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/bubble_sort_ctrl.sv
// Sequencer for an N-entry compare-and-swap sort datapath sharing a single comparator.
// Walks adjacent pairs with a shrinking upper limit and stops early after a pass without swaps.
module bubble_sort_ctrl
    import bubble_sort_ctrl_pkg::*;
#(
    parameter int N     = DEFAULT_N,
    parameter int IDX_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             gt,
    output logic             ld_all,
    output logic             swap,
    output logic [IDX_W-1:0] idx,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] pass_cnt
);

    localparam logic [IDX_W-1:0] LIMIT_INIT = IDX_W'(N - 1);
    localparam logic [IDX_W-1:0] ONE        = IDX_W'(1);

    state_t           state;
    state_t           next_state;
    logic [IDX_W-1:0] limit;
    logic             swapped;
    logic             pass_end;
    logic             finish;

    always_ff @(posedge clk) begin
        if (clr) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The current pass ends on the last pair below limit; the sort ends there if nothing moved.
    always_comb begin
        next_state = state;
        ld_all     = 1'b0;
        swap       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        pass_end   = (idx == limit - ONE);
        finish     = pass_end && (!(swapped | gt) || (limit == ONE));
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                ld_all     = 1'b1;
                busy       = 1'b1;
                next_state = ST_CMP;
            end
            ST_CMP: begin
                busy = 1'b1;
                swap = gt;
                if (finish) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (!start) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Counters are primed on the way into LOAD so they already read as a fresh sort during LOAD.
    always_ff @(posedge clk) begin
        if (clr) begin
            idx      <= '0;
            limit    <= LIMIT_INIT;
            swapped  <= 1'b0;
            pass_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx      <= '0;
                        limit    <= LIMIT_INIT;
                        swapped  <= 1'b0;
                        pass_cnt <= '0;
                    end
                end
                ST_CMP: begin
                    if (pass_end) begin
                        pass_cnt <= pass_cnt + ONE;
                        idx      <= '0;
                        swapped  <= 1'b0;
                        if (!finish) begin
                            limit <= limit - ONE;
                        end
                    end else begin
                        idx     <= idx + ONE;
                        swapped <= swapped | gt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Directed bench: models a 4-entry register file around the sequencer and checks sort results and timing.
module tb_bubble_sort_ctrl;

    localparam int N     = 4;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             clr;
    logic             start;
    logic             gt;
    logic             ld_all;
    logic             swap;
    logic [IDX_W-1:0] idx;
    logic             busy;
    logic             done;
    logic [IDX_W-1:0] pass_cnt;

    logic [7:0]  regs      [0:N-1];
    logic [7:0]  load_vals [0:N-1];
    int          n_checks = 0;
    int          n_fails  = 0;
    int          swap_count;
    int          ld_count;
    int          overlap_err;
    logic [31:0] swap_hist;

    always #5 clk = ~clk;

    bubble_sort_ctrl #(.N(N), .IDX_W(IDX_W)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .gt       (gt),
        .ld_all   (ld_all),
        .swap     (swap),
        .idx      (idx),
        .busy     (busy),
        .done     (done),
        .pass_cnt (pass_cnt)
    );

    // Datapath model: unsigned compare of the selected pair, load-all and swap register writes.
    assign gt = (regs[int'(idx)] > regs[int'(idx) + 1]);

    always @(posedge clk) begin
        if (ld_all) begin
            for (int i = 0; i < N; i++) regs[i] <= load_vals[i];
        end else if (swap) begin
            regs[int'(idx)]     <= regs[int'(idx) + 1];
            regs[int'(idx) + 1] <= regs[int'(idx)];
        end
    end

    always @(negedge clk) begin
        if (swap) begin
            swap_count++;
            swap_hist = {swap_hist[27:0], 2'b00, idx};
        end
        if (ld_all) ld_count++;
        if (swap && (ld_all || !busy)) overlap_err++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Loads vals, pulses start, waits for done and checks latency (cycle offset from k), passes and result.
    task automatic applyStimulus(input string name, input logic [31:0] vals, input logic [31:0] exp_vals,
                                 input int exp_cycle, input int exp_passes, input int exp_swaps,
                                 input logic [31:0] exp_hist, input bit hold);
        int edges;
        for (int i = 0; i < N; i++) load_vals[i] = vals[31 - 8*i -: 8];
        @(negedge clk);
        swap_count  = 0;
        ld_count    = 0;
        overlap_err = 0;
        swap_hist   = '0;
        start       = 1'b1;
        @(posedge clk);
        #1;
        checkOutput({name, "_load"}, {28'd0, ld_all, busy, done, swap}, 32'h0000000C);
        checkOutput({name, "_load_pass"}, {30'd0, pass_cnt}, 32'd0);
        if (!hold) start = 1'b0;
        edges = 0;
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        if (!done) checkOutput({name, "_done_timeout"}, 32'd0, 32'd1);
        checkOutput({name, "_done_cycle"}, 32'(edges + 1), 32'(exp_cycle));
        checkOutput({name, "_pass_cnt"}, {30'd0, pass_cnt}, 32'(exp_passes));
        checkOutput({name, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({name, "_swaps"}, 32'(swap_count), 32'(exp_swaps));
        checkOutput({name, "_swap_idx"}, swap_hist, exp_hist);
        checkOutput({name, "_loads"}, 32'(ld_count), 32'd1);
        checkOutput({name, "_overlap"}, 32'(overlap_err), 32'd0);
        checkOutput({name, "_regs"}, {regs[0], regs[1], regs[2], regs[3]}, exp_vals);
        if (!hold) begin
            @(posedge clk);
            #1;
            checkOutput({name, "_idle"}, {30'd0, done, busy}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < N; i++) begin
            regs[i]      = 8'd0;
            load_vals[i] = 8'd0;
        end
        swap_count  = 0;
        ld_count    = 0;
        overlap_err = 0;
        swap_hist   = '0;
        clr         = 1'b1;
        start       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_outputs", {24'd0, ld_all, swap, idx, busy, done, pass_cnt}, 32'd0);
        @(negedge clk);
        clr = 1'b0;

        applyStimulus("mixed",    32'h03010402, 32'h01020304, 8, 3, 3, 32'h00000021, 1'b0);
        applyStimulus("sorted",   32'h01020304, 32'h01020304, 5, 1, 0, 32'h00000000, 1'b0);
        applyStimulus("reversed", 32'h09070500, 32'h00050709, 8, 3, 6, 32'h00012010, 1'b0);
        applyStimulus("equal",    32'h05050505, 32'h05050505, 5, 1, 0, 32'h00000000, 1'b0);

        // Abort a sort mid-compare, then sort again from scratch.
        load_vals[0] = 8'd9; load_vals[1] = 8'd7; load_vals[2] = 8'd5; load_vals[3] = 8'd0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("clr_in_cmp", {31'd0, busy}, 32'd1);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("clr_outputs", {24'd0, ld_all, swap, idx, busy, done, pass_cnt}, 32'd0);
        @(negedge clk);
        clr = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("clr_stays_idle", {30'd0, busy, done}, 32'd0);
        applyStimulus("after_clr", 32'h09070500, 32'h00050709, 8, 3, 6, 32'h00012010, 1'b0);

        // Held start must not restart from DONE.
        applyStimulus("hold", 32'h03010402, 32'h01020304, 8, 3, 3, 32'h00000021, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checkOutput("hold_done", {31'd0, done}, 32'd1);
        end
        checkOutput("hold_no_reload", 32'(ld_count), 32'd1);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("hold_release", {30'd0, done, busy}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("hold_no_restart", {31'd0, ld_all}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
